// File: rtl/fp_sqrt_arb_pkg.sv
// Shared types and constants for the fp_sqrt_arbiter slice.
// Holds the arbiter FSM encoding and the nominal sqrt engine latency.
package fp_sqrt_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_e;

  localparam int          FP_SQRT_LATENCY = 30;
  localparam logic [31:0] FP_QNAN         = 32'h7FC00000;
  localparam logic [31:0] FP_PINF         = 32'h7F800000;

endpackage

// File: rtl/fp_sqrt_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping.
module fp_sqrt_rr_pick
  import fp_sqrt_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // Scan from ptr upward so the previous winner has lowest priority.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % N_REQ]) begin
        found                         = 1'b1;
        gnt[(int'(ptr) + i) % N_REQ]  = 1'b1;
        idx                           = IDX_W'((int'(ptr) + i) % N_REQ);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/iob_fp_sqrt.sv
// Multi-cycle IEEE-754 single-precision square root engine.
// Uses a digit-by-digit restoring root with round-to-nearest; done pulses LATENCY cycles after start.
module iob_fp_sqrt
  import fp_sqrt_arb_pkg::*;
#(
  parameter int LATENCY = 30
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] op_i,
  output logic [31:0] res_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        exception_o
);

  logic        op_s;
  logic [7:0]  op_e;
  logic [22:0] op_f;
  logic        spec_c;
  logic [31:0] spec_res_c;
  logic        unf_c;
  logic        exc_c;
  logic [8:0]  exp_sum_c;

  logic        run_q;
  logic [5:0]  cnt_q;
  logic [49:0] rad_q;
  logic [27:0] rem_q;
  logic [24:0] root_q;
  logic [7:0]  exp_q;
  logic        spec_q;
  logic [31:0] spec_res_q;
  logic        unf_q;
  logic        exc_q;
  logic [31:0] res_q;
  logic        done_q;
  logic        unf_out_q;
  logic        exc_out_q;

  logic [27:0] rem_t;
  logic [27:0] trial;
  logic        ge;
  logic [27:0] rem_n;
  logic [24:0] root_n;
  logic [24:0] rnd;
  logic [31:0] final_res;

  assign op_s = op_i[31];
  assign op_e = op_i[30:23];
  assign op_f = op_i[22:0];

  // Classify the operand: NaN, zero/denormal (flushed), negative, infinity or normal.
  always_comb begin
    spec_c     = 1'b1;
    spec_res_c = 32'd0;
    unf_c      = 1'b0;
    exc_c      = 1'b0;
    if (op_e == 8'hFF && op_f != 23'd0) begin
      spec_res_c = FP_QNAN;
      exc_c      = 1'b1;
    end else if (op_e == 8'h00) begin
      spec_res_c = {op_s, 31'd0};
      unf_c      = (op_f != 23'd0);
    end else if (op_s) begin
      spec_res_c = FP_QNAN;
      exc_c      = 1'b1;
    end else if (op_e == 8'hFF) begin
      spec_res_c = FP_PINF;
    end else begin
      spec_c = 1'b0;
    end
  end

  // Odd biased exponent means an even unbiased one: halve directly, otherwise borrow one into the mantissa.
  assign exp_sum_c = {1'b0, op_e} + 9'd127 - {8'd0, ~op_e[0]};

  // One restoring root step: two radicand bits in, one root bit out.
  always_comb begin
    rem_t  = {rem_q[25:0], rad_q[49:48]};
    trial  = {1'b0, root_q, 2'b01};
    ge     = (rem_t >= trial);
    rem_n  = ge ? (rem_t - trial) : rem_t;
    root_n = {root_q[23:0], ge};
  end

  // The 25th root bit is the round bit; an exact halfway case cannot occur for sqrt.
  always_comb begin
    rnd = {1'b0, root_q[24:1]} + {24'd0, root_q[0]};
    if (spec_q) begin
      final_res = spec_res_q;
    end else if (rnd[24]) begin
      final_res = {1'b0, exp_q + 8'd1, 23'd0};
    end else begin
      final_res = {1'b0, exp_q, rnd[22:0]};
    end
  end

  // Operand capture, iteration and result/done registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      run_q      <= 1'b0;
      cnt_q      <= 6'd0;
      rad_q      <= 50'd0;
      rem_q      <= 28'd0;
      root_q     <= 25'd0;
      exp_q      <= 8'd0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      unf_q      <= 1'b0;
      exc_q      <= 1'b0;
      res_q      <= 32'd0;
      done_q     <= 1'b0;
      unf_out_q  <= 1'b0;
      exc_out_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        run_q      <= 1'b1;
        cnt_q      <= 6'd1;
        rad_q      <= op_e[0] ? {1'b0, 1'b1, op_f, 25'd0} : {1'b1, op_f, 26'd0};
        rem_q      <= 28'd0;
        root_q     <= 25'd0;
        exp_q      <= exp_sum_c[8:1];
        spec_q     <= spec_c;
        spec_res_q <= spec_res_c;
        unf_q      <= unf_c;
        exc_q      <= exc_c;
      end else if (run_q) begin
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q <= 6'd25) begin
          rem_q  <= rem_n;
          root_q <= root_n;
          rad_q  <= {rad_q[47:0], 2'b00};
        end
        if (cnt_q == 6'(LATENCY - 1)) begin
          run_q     <= 1'b0;
          done_q    <= 1'b1;
          res_q     <= final_res;
          unf_out_q <= unf_q;
          exc_out_q <= exc_q;
        end
      end
    end
  end

  assign res_o       = res_q;
  assign done_o      = done_q;
  assign overflow_o  = 1'b0;
  assign underflow_o = unf_out_q;
  assign exception_o = exc_out_q;

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// Shares one iob_fp_sqrt engine among N_REQ requesters with round-robin arbitration.
// Define FP_SQRT_ARB_EXC_EN to add the exc_o {overflow, underflow, exception} result flags.
module fp_sqrt_arbiter
  import fp_sqrt_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] op_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic [N_REQ-1:0]        res_valid_o,
  input  logic [N_REQ-1:0]        res_ready_i,
  output logic [DATA_W-1:0]       res_o,
  output logic                    busy_o,
  output logic [IDX_W-1:0]        owner_o
`ifdef FP_SQRT_ARB_EXC_EN
  ,
  output logic [2:0]              exc_o
`endif
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [DATA_W-1:0] op_q;
  logic [IDX_W-1:0]  owner_q;
  logic [DATA_W-1:0] res_q;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              load_op;
  logic              load_res;
  logic              eng_start;
  logic [31:0]       eng_res;
  logic              eng_done;
`ifdef FP_SQRT_ARB_EXC_EN
  logic              eng_ovf;
  logic              eng_unf;
  logic              eng_exc;
  logic [2:0]        exc_q;
`endif

  fp_sqrt_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  iob_fp_sqrt #(
    .LATENCY (FP_SQRT_LATENCY)
  ) u_sqrt (
    .clk         (clk),
    .rst_i       (~rst_n),
    .start_i     (eng_start),
    .op_i        (op_q),
    .res_o       (eng_res),
    .done_o      (eng_done),
`ifdef FP_SQRT_ARB_EXC_EN
    .overflow_o  (eng_ovf),
    .underflow_o (eng_unf),
    .exception_o (eng_exc)
`else
    .overflow_o  (),
    .underflow_o (),
    .exception_o ()
`endif
  );

  assign ptr_next = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IDX_W'(1);

  // Next-state and handshake decode; ack is combinational in the IDLE cycle.
  always_comb begin
    state_d   = state_q;
    ack_o     = '0;
    load_op   = 1'b0;
    load_res  = 1'b0;
    eng_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          ack_o   = pick_gnt;
          load_op = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        eng_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          load_res = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (res_ready_i[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand, owner, round-robin pointer and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_ptr  <= '0;
      op_q    <= '0;
      owner_q <= '0;
      res_q   <= '0;
`ifdef FP_SQRT_ARB_EXC_EN
      exc_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      if (load_op) begin
        op_q    <= op_i[int'(pick_idx)*DATA_W +: DATA_W];
        owner_q <= pick_idx;
        rr_ptr  <= ptr_next;
      end
      if (load_res) begin
        res_q <= eng_res;
`ifdef FP_SQRT_ARB_EXC_EN
        exc_q <= {eng_ovf, eng_unf, eng_exc};
`endif
      end
    end
  end

  // Valid is decoded from registered state and owner only.
  always_comb begin
    res_valid_o = '0;
    if (state_q == ST_HOLD) begin
      res_valid_o[owner_q] = 1'b1;
    end else begin
      res_valid_o = '0;
    end
  end

  assign res_o   = res_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign owner_o = owner_q;
`ifdef FP_SQRT_ARB_EXC_EN
  assign exc_o   = exc_q;
`endif

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Randomized self-checking bench for fp_sqrt_arbiter against a transaction-level model.
// Honours FP_SQRT_ARB_EXC_EN for the exception-flag checks.
module tb_fp_sqrt_arbiter;
  import fp_sqrt_arb_pkg::*;

  localparam int L = FP_SQRT_LATENCY;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_i;
  logic [127:0] op_i;
  logic [3:0]   ack_o;
  logic [3:0]   res_valid_o;
  logic [3:0]   res_ready_i;
  logic [31:0]  res_o;
  logic         busy_o;
  logic [1:0]   owner_o;
`ifdef FP_SQRT_ARB_EXC_EN
  logic [2:0]   exc_o;
`endif

  fp_sqrt_arbiter #(.DATA_W(32), .N_REQ(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .op_i        (op_i),
    .ack_o       (ack_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_o       (res_o),
    .busy_o      (busy_o),
    .owner_o     (owner_o)
`ifdef FP_SQRT_ARB_EXC_EN
    ,
    .exc_o       (exc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: pending requests, operands, expected results, in-flight transaction.
  logic [3:0]  pend = 4'd0;
  logic [3:0]  wd = 4'd0;
  logic [31:0] ops[4];
  logic [31:0] exp_r[4];
  logic [2:0]  exp_exc[4];
  logic [31:0] cur_exp = 32'd0;
  logic [2:0]  cur_exc = 3'd0;
  bit          inflight = 1'b0;
  bit          refill = 1'b0;
  int          ack_cyc = 0;
  int          owner_m = 0;
  int          ptr_m = 0;
  int          bp = 0;
  int          cyc = 0;
  int          grants[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Float bits of mag * 2^p2 (mag exact in 24 bits).
  function automatic logic [31:0] fp_of(input int unsigned mag, input int p2);
    logic [31:0] m;
    logic [31:0] sh;
    int b;
    int e;
    m = mag;
    b = 0;
    for (int i = 0; i < 32; i++) if (m[i]) b = i;
    sh = m << (23 - b);
    e = b + p2 + 127;
    return {1'b0, e[7:0], sh[22:0]};
  endfunction

  task automatic gen(input int k);
    int unsigned kv;
    int s;
    kv = $urandom_range(1, 4095);
    s = int'($urandom_range(0, 40)) - 20;
    ops[k] = fp_of(kv * kv, 2 * s);
    exp_r[k] = fp_of(kv, s);
    exp_exc[k] = 3'd0;
  endtask

  task automatic step();
    logic [3:0] rq;
    logic [3:0] e_ack;
    logic [3:0] e_val;
    int win;
    bit in_hold;
    @(negedge clk);
    cyc++;
    rq = pend | wd;
    wd = 4'd0;
    req_i = rq;
    for (int k = 0; k < 4; k++) op_i[k*32 +: 32] = ops[k];
    in_hold = inflight && (cyc >= ack_cyc + 2 + L);
    res_ready_i = 4'($urandom_range(0, 15));
    if (inflight) res_ready_i[owner_m] = ((cyc - (ack_cyc + 2 + L)) >= bp);
    #1;
    e_ack = 4'd0;
    win = -1;
    if (!inflight && rq != 4'd0) begin
      for (int i = 0; i < 4; i++) if (win < 0 && rq[(ptr_m + i) % 4]) win = (ptr_m + i) % 4;
      e_ack[win] = 1'b1;
    end
    chk("ack", 64'(ack_o), 64'(e_ack));
    chk("busy", 64'(busy_o), 64'(inflight));
    chk("owner", 64'(owner_o), 64'(owner_m));
    e_val = 4'd0;
    if (in_hold) e_val[owner_m] = 1'b1;
    chk("valid", 64'(res_valid_o), 64'(e_val));
    if (in_hold) begin
      chk("res", 64'(res_o), 64'(cur_exp));
`ifdef FP_SQRT_ARB_EXC_EN
      chk("exc", 64'(exc_o), 64'(cur_exc));
`endif
      if (res_ready_i[owner_m]) inflight = 1'b0;
    end
    if (win >= 0) begin
      inflight = 1'b1;
      ack_cyc = cyc;
      owner_m = win;
      ptr_m = (win + 1) % 4;
      cur_exp = exp_r[win];
      cur_exc = exp_exc[win];
      grants.push_back(win);
      if (!refill) pend[win] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inflight || pend != 4'd0) && n < 2000) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(inflight || pend != 4'd0), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_i = 4'd0;
    pend = 4'd0;
    wd = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc += 2;
    #1;
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_valid", 64'(res_valid_o), 64'd0);
    chk("rst_res", 64'(res_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_owner", 64'(owner_o), 64'd0);
    inflight = 1'b0;
    owner_m = 0;
    ptr_m = 0;
  endtask

  initial begin
    int base;
    int n;
    int cnt1;
    rst_n = 1'b0;
    req_i = 4'd0;
    op_i = 128'd0;
    res_ready_i = 4'd0;
    for (int k = 0; k < 4; k++) begin
      ops[k] = 32'd0;
      exp_r[k] = 32'd0;
      exp_exc[k] = 3'd0;
    end
    do_reset();

    // Single request: sqrt(4.0) = 2.0
    ops[0] = 32'h40800000; exp_r[0] = 32'h40000000;
    pend = 4'b0001; bp = 0;
    drain();
    chk("single_grant", 64'(grants[0]), 64'd0);

    // Round-robin fairness with all four requesting continuously
    do_reset();
    for (int k = 0; k < 4; k++) begin ops[k] = 32'h41100000; exp_r[k] = 32'h40400000; end
    base = grants.size();
    pend = 4'b1111; refill = 1'b1;
    n = 0;
    while (grants.size() < base + 5 && n < 1000) begin step(); n++; end
    refill = 1'b0; pend = 4'd0;
    drain();
    chk("rr_count", 64'(grants.size() - base), 64'd5);
    for (int i = 0; i < 5; i++) if (grants.size() > base + i) chk("rr_order", 64'(grants[base + i]), 64'(i % 4));

    // Backpressure on requester 2, requester 0 waiting behind it
    ops[2] = 32'h41800000; exp_r[2] = 32'h40800000;
    ops[0] = 32'h40800000; exp_r[0] = 32'h40000000;
    base = grants.size();
    pend = 4'b0101; bp = 10;
    drain();
    bp = 0;
    chk("bp_first", 64'(grants[base]), 64'd2);

    // Reset during WAIT, then requesters 1 and 3 compete from rr_ptr 0
    gen(2); pend = 4'b0100;
    n = 0;
    while (!(inflight && cyc >= ack_cyc + 5) && n < 100) begin step(); n++; end
    do_reset();
    gen(1); gen(3);
    base = grants.size();
    pend = 4'b1010;
    drain();
    chk("rst_count", 64'(grants.size() - base), 64'd2);
    if (grants.size() >= base + 2) begin
      chk("rst_pick0", 64'(grants[base]), 64'd1);
      chk("rst_pick1", 64'(grants[base + 1]), 64'd3);
    end

    // Withdrawn request from requester 1 while busy
    gen(0);
    base = grants.size();
    pend = 4'b0001;
    step();
    step();
    wd = 4'b0010;
    drain();
    cnt1 = 0;
    for (int i = base; i < grants.size(); i++) if (grants[i] == 1) cnt1++;
    chk("wd_never", 64'(cnt1), 64'd0);

`ifdef FP_SQRT_ARB_EXC_EN
    // Exception flags: sqrt(-1.0), then a clean op
    ops[0] = 32'hBF800000; exp_r[0] = 32'h7FC00000; exp_exc[0] = 3'b001;
    pend = 4'b0001;
    drain();
    ops[0] = 32'h40800000; exp_r[0] = 32'h40000000; exp_exc[0] = 3'b000;
    pend = 4'b0001;
    drain();
`endif

    // Random traffic with random backpressure and withdrawals
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 7) == 0) begin gen(k); pend[k] = 1'b1; end
      end
      if (inflight && $urandom_range(0, 15) == 0) wd = 4'($urandom_range(0, 15)) & ~pend;
      bp = $urandom_range(0, 3);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
